button_conditioner: RTL

- Input-conditioning stage directly upstream of the timer/clock core.
- Takes raw, bouncy push-button and DIP lines from board pins. Synchronises and debounces each one.
- Produces clean level outputs plus one-cycle press/release pulses. The timer core uses these for pause/resume, set-mode, power and minute/second increments.
- Optional hold-to-autorepeat generates repeated press pulses for fast time setting.

---
 rtl/button_conditioner.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and edge-detect push-button and DIP inputs
// Optional hold-to-autorepeat of press pulses: define BUTTON_CONDITIONER_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int NUM_BTN          = 6,
    parameter int CLK_HZ           = 50_000_000,
    parameter int DEBOUNCE_MS      = 20,
    parameter bit ACTIVE_LOW       = 1'b1,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o
);

    localparam int CYC_PER_MS = CLK_HZ / 1000;
    localparam int DB_CYCLES  = CYC_PER_MS * DEBOUNCE_MS;
    localparam int CNT_W      = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    // A one-cycle debounce window cannot reject any glitch.
    if (DB_CYCLES < 2) begin : g_db_check
        $error("button_conditioner: DB_CYCLES must be at least 2");
    end

    // Negative repeat timings are meaningless in every build.
    if (REPEAT_DELAY_MS < 0 || REPEAT_PERIOD_MS < 0) begin : g_rpt_sign_check
        $error("button_conditioner: REPEAT_*_MS must be non-negative");
    end

    // Normalise polarity so everything downstream sees 1 = pressed.
    logic [NUM_BTN-1:0] pol_in;
    assign pol_in = ACTIVE_LOW ? ~btn_raw_i : btn_raw_i;

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    // Two-flop metastability synchroniser, nothing between the stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pol_in;
            sync2_q <= sync1_q;
        end
    end

    logic [NUM_BTN-1:0]            level_q;
    logic [NUM_BTN-1:0]            level_d;
    logic [NUM_BTN-1:0][CNT_W-1:0] db_cnt_q;
    logic [NUM_BTN-1:0][CNT_W-1:0] db_cnt_d;
    logic [NUM_BTN-1:0]            rise;
    logic [NUM_BTN-1:0]            fall;
    logic [NUM_BTN-1:0]            rpt_fire;

    // Debounce: count consecutive samples that disagree with the level; any agreeing sample restarts.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        rise     = '0;
        fall     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                level_d[i]  = sync2_q[i];
                db_cnt_d[i] = '0;
                rise[i]     = sync2_q[i];
                fall[i]     = ~sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int RPT_DELAY_CYC  = CYC_PER_MS * REPEAT_DELAY_MS;
    localparam int RPT_PERIOD_CYC = CYC_PER_MS * REPEAT_PERIOD_MS;
    localparam int RPT_MAX        = (RPT_DELAY_CYC > RPT_PERIOD_CYC) ? RPT_DELAY_CYC : RPT_PERIOD_CYC;
    localparam int RPT_W          = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(RPT_DELAY_CYC - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(RPT_PERIOD_CYC - 1);

    // Zero-length repeat intervals would make the counter compare against -1.
    if (RPT_DELAY_CYC < 1 || RPT_PERIOD_CYC < 1) begin : g_rpt_check
        $error("button_conditioner: repeat delay and period must be at least one clock");
    end

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_PERIOD = 2'd2
    } rpt_state_e;

    rpt_state_e                    rpt_state_q [NUM_BTN];
    rpt_state_e                    rpt_state_d [NUM_BTN];
    logic [NUM_BTN-1:0][RPT_W-1:0] rpt_cnt_q;
    logic [NUM_BTN-1:0][RPT_W-1:0] rpt_cnt_d;

    // Repeat FSM state register: one small FSM and counter per channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                rpt_state_q[i] <= RPT_IDLE;
            end
            rpt_cnt_q <= '0;
        end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    // Repeat next state: restart on every debounced press, wait the initial delay, then cycle the period.
    always_comb begin
        rpt_state_d = rpt_state_q;
        rpt_cnt_d   = rpt_cnt_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (rise[i]) begin
                rpt_state_d[i] = RPT_DELAY;
                rpt_cnt_d[i]   = '0;
            end else if (fall[i] || !level_q[i]) begin
                rpt_state_d[i] = RPT_IDLE;
                rpt_cnt_d[i]   = '0;
            end else begin
                case (rpt_state_q[i])
                    RPT_DELAY: begin
                        if (rpt_cnt_q[i] == RPT_DELAY_LAST) begin
                            rpt_state_d[i] = RPT_PERIOD;
                            rpt_cnt_d[i]   = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
                        end
                    end
                    RPT_PERIOD: begin
                        if (rpt_cnt_q[i] == RPT_PERIOD_LAST) begin
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
                        end
                    end
                    default: begin
                        rpt_state_d[i] = RPT_IDLE;
                        rpt_cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Repeat output: fire at the end of each interval while held; a same-edge release suppresses it.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (level_q[i] && !fall[i]) begin
                if (rpt_state_q[i] == RPT_DELAY && rpt_cnt_q[i] == RPT_DELAY_LAST) begin
                    rpt_fire[i] = 1'b1;
                end else if (rpt_state_q[i] == RPT_PERIOD && rpt_cnt_q[i] == RPT_PERIOD_LAST) begin
                    rpt_fire[i] = 1'b1;
                end
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] release_q;

    // Registered one-cycle pulses aligned with the level update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= rise | rpt_fire;
            release_q <= fall;
        end
    end

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;

endmodule
